stack_ctrl: RTL and testbench
=============================

// Module: stack_ctrl
// PURPOSE
//   Push/pop controller on the CPU side of memstack. Owns the stack pointer and
//   turns CPU push/pop requests into memstack address/we/data_in.
//   Captures memstack data_out on pops and reports full/empty/overflow/underflow.
//   Sits between the CPU control unit (CALL/RET, PUSH/POP) and one memstack instance.
// PARAMETERS
//   WIDTH   16    data word width; must match memstack WIDTH
//   NWORDS  1024  stack depth in words; must match memstack NWORDS (any value >= 2)
//   AW      $clog2(NWORDS)  localparam, memstack address width
// PORTS
//   clk        in   1        system clock, rising edge
//   reset      in   1        asynchronous, active-high reset
//   push       in   1        push request, sampled each clk
//   pop        in   1        pop request, sampled each clk
//   flush      in   1        synchronous empty: sp<=0, error flags cleared
//   push_data  in   WIDTH    word to push
//   pop_data   out  WIDTH    registered popped word
//   pop_valid  out  1        1-cycle pulse: pop_data updated this cycle
//   top        out  WIDTH    combinational top-of-stack (mem_dout); 0 when empty
//   count      out  AW+1     words currently stored (== sp)
//   empty      out  1        count == 0
//   full       out  1        count == NWORDS
//   overflow   out  1        sticky: push attempted while full
//   underflow  out  1        sticky: pop attempted while empty
//   mem_a      out  AW       to memstack a
//   mem_we     out  1        to memstack we
//   mem_din    out  WIDTH    to memstack data_in (== push_data)
//   mem_dout   in   WIDTH    from memstack data_out (asynchronous read)
// BEHAVIOUR
//   Reset: sp=0, pop_data=0, pop_valid=0, overflow=0, underflow=0 -> empty=1, full=0.
//   sp (AW+1 bits) points at next free slot; top item lives at sp-1.
//   mem_a/mem_we combinational from sp, push, pop, full, empty:
//     push only, !full        : mem_a=sp[AW-1:0], mem_we=1; sp<=sp+1
//     pop only, !empty        : mem_a=sp-1, mem_we=0; pop_data<=mem_dout, pop_valid<=1, sp<=sp-1
//     push&pop, !empty        : replace top: mem_a=sp-1, mem_we=1; pop_data<=old top
//                               (mem_dout before edge), pop_valid<=1, sp unchanged
//     push&pop, empty         : push proceeds at sp=0; pop ignored; underflow<=1; pop_valid<=0
//     push only, full         : mem_we=0, sp unchanged, overflow<=1
//     pop only, empty         : sp unchanged, pop_valid<=0, underflow<=1, pop_data holds
//     idle                    : mem_we=0; mem_a=sp-1 if !empty else 0
//   pop latency: pop_data/pop_valid valid the cycle after the pop request (1 clk).
//   pop_valid deasserts the following cycle unless another valid pop occurs.
//   top = empty ? 0 : mem_dout (mem_a is sp-1 whenever not pushing-only).
//   flush has priority over push/pop: sp<=0, overflow<=0, underflow<=0, mem_we=0,
//     pop_valid<=0; stack contents untouched.
//   No wrap-around: sp never exceeds NWORDS nor goes below 0; all index math mod 2^AW
//     only used when in range.
//   Reset mid-operation: all state to reset values immediately; a write strobed the
//     same edge is not guaranteed (memstack reset overrides we).
// STRUCTURE
//   stack_defs.vh: default WIDTH/NWORDS, shared with memstack and CPU top.
//   One sub-module: stack_ptr (sp register, inc/dec/hold/clear, full/empty decode).
//   Flags, pop_data register and mem_* muxing stay in stack_ctrl.
// TESTING (stack_ctrl + memstack, WIDTH=16, NWORDS=4)
//   reset -> count=0, empty=1, full=0, pop_valid=0, flags=0, top=0.
//   push 0x1111,0x2222,0x3333 -> count=3, top=0x3333; pop -> next cycle pop_data=0x3333,
//     pop_valid=1, count=2, top=0x2222.
//   fill to 4 then push 0xDEAD -> full=1, overflow=1, count=4, mem_we=0, top unchanged.
//   empty stack, pop -> underflow=1, pop_valid=0, count=0; push&pop 0xBEEF -> count=1,
//     top=0xBEEF, pop_valid=0.
//   stack [0x1111,0x2222], push&pop 0x9999 -> pop_data=0x2222, pop_valid=1, count=2,
//     top=0x9999.
//   flush with overflow set, then async reset asserted mid-push -> count=0, flags=0,
//     pop_valid=0 immediately, no further writes.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared defaults and decode types for the CPU-side stack controller.
// Data width and depth must match the memstack instance that the controller drives.
package stack_ctrl_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_NWORDS = 1024;

    // Stack pointer update requested by the controller each cycle
    typedef enum logic [1:0] {
        SP_HOLD = 2'd0,
        SP_INC  = 2'd1,
        SP_DEC  = 2'd2,
        SP_CLR  = 2'd3
    } sp_op_e;

    // Resolved request after priority and full/empty qualification
    typedef enum logic [2:0] {
        OP_IDLE     = 3'd0,
        OP_PUSH     = 3'd1,
        OP_POP      = 3'd2,
        OP_REPLACE  = 3'd3,
        OP_PUSH_UF  = 3'd4,
        OP_OVERFLOW = 3'd5,
        OP_UNDERFLW = 3'd6,
        OP_FLUSH    = 3'd7
    } ctrl_op_e;

    function automatic ctrl_op_e decode_op(
        input logic flush,
        input logic push,
        input logic pop,
        input logic full,
        input logic empty
    );
        ctrl_op_e op;
        op = OP_IDLE;
        if (flush)
            op = OP_FLUSH;
        else if (push && pop)
            op = empty ? OP_PUSH_UF : OP_REPLACE;
        else if (push)
            op = full ? OP_OVERFLOW : OP_PUSH;
        else if (pop)
            op = empty ? OP_UNDERFLW : OP_POP;
        return op;
    endfunction

    function automatic sp_op_e sp_op_for(input ctrl_op_e op);
        sp_op_e s;
        s = SP_HOLD;
        case (op)
            OP_PUSH, OP_PUSH_UF: s = SP_INC;
            OP_POP:              s = SP_DEC;
            OP_FLUSH:            s = SP_CLR;
            default:             s = SP_HOLD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stack_ctrl_ptr.sv
// Stack pointer register with inc/dec/hold/clear plus full/empty decode.
// Latency: sp updates on the clock edge after the op; no backpressure (caller qualifies ops).
module stack_ptr
    import stack_ctrl_pkg::*;
#(
    parameter int  NWORDS = DEF_NWORDS,
    localparam int AW     = $clog2(NWORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  sp_op_e        op,
    output logic [AW:0]   sp,
    output logic [AW-1:0] sp_m1,
    output logic          empty,
    output logic          full
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(NWORDS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else begin
            case (op)
                SP_INC:  sp <= sp + (AW+1)'(1);
                SP_DEC:  sp <= sp - (AW+1)'(1);
                SP_CLR:  sp <= '0;
                default: sp <= sp;
            endcase
        end
    end

    // Only meaningful when not empty; wraps harmlessly otherwise
    assign sp_m1 = sp[AW-1:0] - AW'(1);
    assign empty = (sp == '0);
    assign full  = (sp == FULL_CNT);

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop controller between the CPU control unit and one memstack instance.
// Latency: pop_data/pop_valid one clk after a pop; no backpressure, rejected ops raise sticky flags.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int  WIDTH  = DEF_WIDTH,
    parameter int  NWORDS = DEF_NWORDS,
    localparam int AW     = $clog2(NWORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] top,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic [AW-1:0]    mem_a,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_din,
    input  logic [WIDTH-1:0] mem_dout
);

    logic [AW:0]   sp;
    logic [AW-1:0] sp_m1;
    ctrl_op_e      op;
    sp_op_e        sp_op;

    stack_ptr #(
        .NWORDS (NWORDS)
    ) u_ptr (
        .clk   (clk),
        .reset (reset),
        .op    (sp_op),
        .sp    (sp),
        .sp_m1 (sp_m1),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        op     = decode_op(flush, push, pop, full, empty);
        sp_op  = sp_op_for(op);
        mem_we = 1'b0;
        mem_a  = empty ? '0 : sp_m1;
        case (op)
            OP_PUSH, OP_PUSH_UF: begin
                mem_a  = sp[AW-1:0];
                mem_we = 1'b1;
            end
            // Replace overwrites the top slot while its old value is read out
            OP_REPLACE: begin
                mem_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            case (op)
                OP_POP, OP_REPLACE: begin
                    pop_data  <= mem_dout;
                    pop_valid <= 1'b1;
                end
                OP_OVERFLOW: overflow <= 1'b1;
                OP_UNDERFLW, OP_PUSH_UF: underflow <= 1'b1;
                OP_FLUSH: begin
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign top     = empty ? '0 : mem_dout;
    assign count   = sp;
    assign mem_din = push_data;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench: stack_ctrl with a behavioural memstack, WIDTH=16, NWORDS=4.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push = 1'b0, pop = 1'b0, flush = 1'b0;
    logic [15:0] push_data = '0;
    logic [15:0] pop_data, top, mem_din, mem_dout;
    logic        pop_valid, empty, full, overflow, underflow, mem_we;
    logic [2:0]  count;
    logic [1:0]  mem_a;
    logic [15:0] mem [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_ctrl #(.WIDTH(16), .NWORDS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (push_data),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .mem_a     (mem_a),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // memstack stand-in: synchronous write, asynchronous read, reset clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_a] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_a];

    typedef struct {
        logic        push, pop, flush;
        logic [15:0] din;
        logic [2:0]  count;
        logic        empty, full;
        logic [15:0] top;
        logic        pv;
        logic [15:0] pd;
        logic        ovf, uf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic p, input logic po, input logic f, input logic [15:0] d,
                       input logic [2:0] c, input logic e, input logic fu,
                       input logic [15:0] t, input logic pv, input logic [15:0] pd,
                       input logic ov, input logic u);
        vec_t v;
        v.push = p; v.pop = po; v.flush = f; v.din = d;
        v.count = c; v.empty = e; v.full = fu; v.top = t;
        v.pv = pv; v.pd = pd; v.ovf = ov; v.uf = u;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One request cycle; outputs are compared afterwards with inputs idle
    task automatic apply(input logic p, input logic po, input logic f, input logic [15:0] d);
        @(negedge clk);
        push = p; pop = po; flush = f; push_data = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0;
        #1;
    endtask

    initial begin
        //   push pop flsh data      cnt e  f  top       pv pd        ov uf
        add(1, 0, 0, 16'h1111, 3'd1, 0, 0, 16'h1111, 0, 16'h0000, 0, 0);
        add(1, 0, 0, 16'h2222, 3'd2, 0, 0, 16'h2222, 0, 16'h0000, 0, 0);
        add(1, 0, 0, 16'h3333, 3'd3, 0, 0, 16'h3333, 0, 16'h0000, 0, 0);
        add(0, 1, 0, 16'h0000, 3'd2, 0, 0, 16'h2222, 1, 16'h3333, 0, 0);
        add(0, 0, 0, 16'h0000, 3'd2, 0, 0, 16'h2222, 0, 16'h3333, 0, 0);
        add(1, 0, 0, 16'h4444, 3'd3, 0, 0, 16'h4444, 0, 16'h3333, 0, 0);
        add(1, 0, 0, 16'h5555, 3'd4, 0, 1, 16'h5555, 0, 16'h3333, 0, 0);
        add(1, 0, 0, 16'hDEAD, 3'd4, 0, 1, 16'h5555, 0, 16'h3333, 1, 0);
        add(1, 1, 0, 16'h6666, 3'd4, 0, 1, 16'h6666, 1, 16'h5555, 1, 0);
        add(0, 0, 1, 16'h0000, 3'd0, 1, 0, 16'h0000, 0, 16'h5555, 0, 0);
        add(0, 1, 0, 16'h0000, 3'd0, 1, 0, 16'h0000, 0, 16'h5555, 0, 1);
        add(1, 1, 0, 16'hBEEF, 3'd1, 0, 0, 16'hBEEF, 0, 16'h5555, 0, 1);
        add(1, 1, 1, 16'hAAAA, 3'd0, 1, 0, 16'h0000, 0, 16'h5555, 0, 0);
        add(1, 0, 0, 16'h1111, 3'd1, 0, 0, 16'h1111, 0, 16'h5555, 0, 0);
        add(1, 0, 0, 16'h2222, 3'd2, 0, 0, 16'h2222, 0, 16'h5555, 0, 0);
        add(1, 1, 0, 16'h9999, 3'd2, 0, 0, 16'h9999, 1, 16'h2222, 0, 0);
        add(0, 1, 0, 16'h0000, 3'd1, 0, 0, 16'h1111, 1, 16'h9999, 0, 0);
        add(0, 1, 0, 16'h0000, 3'd0, 1, 0, 16'h0000, 1, 16'h1111, 0, 0);
        add(0, 1, 0, 16'h0000, 3'd0, 1, 0, 16'h0000, 0, 16'h1111, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_pop_valid", 32'(pop_valid), 0);
        chk("rst_pop_data", 32'(pop_data), 0);
        chk("rst_flags", {30'd0, overflow, underflow}, 0);
        chk("rst_top", 32'(top), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].din);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].count));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].empty));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].full));
            chk($sformatf("v%0d_top", i), 32'(top), 32'(vecs[i].top));
            chk($sformatf("v%0d_pop_valid", i), 32'(pop_valid), 32'(vecs[i].pv));
            chk($sformatf("v%0d_pop_data", i), 32'(pop_data), 32'(vecs[i].pd));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_underflow", i), 32'(underflow), 32'(vecs[i].uf));
        end

        // Overflow: no write strobe while full, top untouched
        apply(1'b1, 1'b0, 1'b0, 16'h00A1);
        apply(1'b1, 1'b0, 1'b0, 16'h00A2);
        apply(1'b1, 1'b0, 1'b0, 16'h00A3);
        apply(1'b1, 1'b0, 1'b0, 16'h00A4);
        chk("fill_full", 32'(full), 1);
        @(negedge clk);
        push = 1'b1; push_data = 16'hDEAD;
        #1;
        chk("ovf_mem_we", 32'(mem_we), 0);
        chk("ovf_top_pre", 32'(top), 32'h00A4);
        @(posedge clk);
        #1;
        push = 1'b0;
        #1;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_top", 32'(top), 32'h00A4);
        apply(1'b0, 1'b0, 1'b1, 16'h0000);
        chk("flush_ovf", 32'(overflow), 0);
        chk("flush_count", 32'(count), 0);
        chk("flush_top", 32'(top), 0);

        // Asynchronous reset mid-push, with pop_valid high beforehand
        apply(1'b1, 1'b0, 1'b0, 16'h00B1);
        apply(1'b1, 1'b0, 1'b0, 16'h00B2);
        apply(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("prerst_pv", 32'(pop_valid), 1);
        chk("prerst_pd", 32'(pop_data), 32'h00B2);
        apply(1'b1, 1'b0, 1'b0, 16'hDEAD);
        chk("prerst_ovf", 32'(overflow), 0);
        @(negedge clk);
        push = 1'b1; push_data = 16'h7777;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_pv", 32'(pop_valid), 0);
        chk("arst_pd", 32'(pop_data), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_flags", {30'd0, overflow, underflow}, 0);
        chk("arst_top", 32'(top), 0);
        @(posedge clk);
        #1;
        chk("arst_hold_count", 32'(count), 0);
        @(negedge clk);
        push = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_top", 32'(top), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
